uart_cmd_ctrl: RTL and testbench
================================

// Module: uart_cmd_ctrl
// PURPOSE
//  Parametrised UART command controller: decodes byte frames from a byte-level UART into register/RAM
//  writes, reads, soft-reset and run pulses, returning read data and ACK/NAK bytes. Successor to the
//  fixed-width controller: multi-byte address, independent write/read widths, variable-latency read
//  handshake, inter-byte timeout, ACK/NAK responses and a STATUS command. Sits between the UART byte core and the CRG datapath.
// PARAMETERS
//  DIN_W       32    write data width, bits; multiple of 8, >=8
//  DOUT_W      32    read data width, bits; multiple of 8, >=8
//  ADDR_BYTES  1     address bytes per frame, 1..4
//  TIMEOUT_CYC 2**20 max idle cycles between frame bytes / before rd_ack; >=2
// PORTS
//  clk       in   1              clock, all logic on rising edge
//  rst       in   1              asynchronous active-high reset
//  rx_valid  in   1              1-cycle strobe, rx_data holds a received byte
//  rx_data   in   8              received byte
//  tx_valid  out  1              byte offered to UART TX
//  tx_ready  in   1              UART TX accepts byte when tx_valid&tx_ready
//  tx_data   out  8              byte to transmit
//  addr      out  8*ADDR_BYTES   target address for write/read
//  wr_data   out  DIN_W          write data, valid with wr_en
//  wr_en     out  1              1-cycle write strobe
//  rd_req    out  1              read request, held until rd_ack
//  rd_ack    in   1              rd_data valid this cycle
//  rd_data   in   DOUT_W         read data
//  swrst     out  1              1-cycle soft-reset pulse
//  run       out  1              1-cycle run pulse
//  err_cnt   out  8              saturating count of timeouts, NAKs and dropped bytes
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, err_cnt 0; asserting rst mid-frame or mid-TX aborts immediately, tx_valid drops.
//  Commands (first byte in IDLE): 0x10 WRITE, 0x20 READ, 0x30 SWRST, 0x40 RUN, 0x50 STATUS; other -> NAK.
//  States: IDLE, ADDR, WDATA, WCOMMIT, RWAIT, RDATA, RESP.
//  IDLE: 0x10/0x20 -> ADDR; 0x30/0x40 -> swrst/run pulse on cycle after byte strobe, send ACK 0xA5 (RESP);
//   0x50 -> RESP sending err_cnt; unknown -> RESP sending NAK 0x5A, err_cnt++.
//  ADDR: ADDR_BYTES bytes, MSB first, shifted into addr; then WDATA (write) or RWAIT (read).
//  WDATA: DIN_W/8 bytes, first byte lands in wr_data[7:0] (shift in from top). After last byte -> WCOMMIT.
//  WCOMMIT: wr_en=1 for exactly one cycle, addr/wr_data stable; -> RESP sending ACK 0xA5.
//  RWAIT: rd_req=1 from entry until rd_ack cycle; rd_data captured on rd_ack; -> RDATA.
//   No rd_ack within TIMEOUT_CYC cycles: rd_req drops, NAK 0x5A sent, err_cnt++.
//  RDATA: DOUT_W/8 bytes transmitted MSB first; -> IDLE after last handshake.
//  RESP: one byte; -> IDLE after handshake.
//  TX handshake: tx_data stable while tx_valid&!tx_ready; at most one byte per accepting cycle;
//   tx_valid may assert one cycle after entry; back-to-back bytes allowed.
//  rx_valid during RWAIT/RDATA/RESP/WCOMMIT: byte dropped, err_cnt++.
//  Timeout: in ADDR or WDATA, TIMEOUT_CYC cycles with no rx_valid -> IDLE, partial frame discarded,
//   no wr_en, err_cnt++; counter restarts on every accepted byte.
//  err_cnt saturates at 0xFF; simultaneous error events in one cycle count once.
//  STATUS returns err_cnt value sampled on the command byte, then clears err_cnt to 0.
// TESTING (DIN_W=DOUT_W=32, ADDR_BYTES=2)
//  10 12 34 EF BE AD DE -> wr_en 1 cycle, addr=0x1234, wr_data=0xDEADBEEF; TX 0xA5.
//  20 00 07, rd_ack 5 cycles later with 0xCAFEF00D -> rd_req held 5 cycles; TX CA FE F0 0D.
//  30 then 40 -> swrst then run single-cycle pulses; TX A5, A5; tx_ready held low 10 cycles keeps A5 stable.
//  10 00 01 AA then silence > TIMEOUT_CYC -> no wr_en, err_cnt=1; 0x77 -> NAK 5A, err_cnt=2; 50 -> TX 02, err_cnt=0.
//  rst pulsed mid-RDATA of 20 00 07 -> tx_valid/rd_req 0 immediately; next 10 frame completes normally.
//  Read with no rd_ack (TIMEOUT_CYC=16) -> rd_req drops after 16 cycles, TX 5A, err_cnt=1.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: turns received byte frames into register writes, reads,
// soft-reset and run pulses, and answers with read data, ACK/NAK or the error count.
module uart_cmd_ctrl #(
    parameter int DIN_W       = 32,
    parameter int DOUT_W      = 32,
    parameter int ADDR_BYTES  = 1,
    parameter int TIMEOUT_CYC = 2**20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [7:0]              tx_data,
    output logic [8*ADDR_BYTES-1:0] addr,
    output logic [DIN_W-1:0]        wr_data,
    output logic                    wr_en,
    output logic                    rd_req,
    input  logic                    rd_ack,
    input  logic [DOUT_W-1:0]       rd_data,
    output logic                    swrst,
    output logic                    run,
    output logic [7:0]              err_cnt
);

    localparam int AW   = 8 * ADDR_BYTES;
    localparam int WB   = DIN_W / 8;
    localparam int RB   = DOUT_W / 8;
    localparam int MAXA = (ADDR_BYTES > WB) ? ADDR_BYTES : WB;
    localparam int MAXB = (MAXA > RB) ? MAXA : RB;
    localparam int CW   = $clog2(MAXB + 1);
    localparam int TW   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BYTES - 1);
    localparam logic [CW-1:0] WR_LAST   = CW'(WB - 1);
    localparam logic [CW-1:0] RD_LAST   = CW'(RB - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CMD_WRITE  = 8'h10;
    localparam logic [7:0] CMD_READ   = 8'h20;
    localparam logic [7:0] CMD_SWRST  = 8'h30;
    localparam logic [7:0] CMD_RUN    = 8'h40;
    localparam logic [7:0] CMD_STATUS = 8'h50;
    localparam logic [7:0] ACK        = 8'hA5;
    localparam logic [7:0] NAK        = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WCOMMIT,
        RWAIT,
        RDATA,
        RESP
    } state_t;

    state_t              state;
    logic                is_read;
    logic [CW-1:0]       byte_cnt;
    logic [TW-1:0]       timer;
    logic [DOUT_W-1:0]   rd_buf;
    logic [AW-1:0]       addr_next;
    logic [DIN_W-1:0]    wdata_next;
    logic                timed_out;
    logic                err_event;
    logic                status_cmd;

    // Address shifts in MSB first; write data shifts in from the top so the first byte ends up lowest.
    always_comb begin
        addr_next        = addr << 8;
        addr_next[7:0]   = rx_data;
        wdata_next       = wr_data >> 8;
        wdata_next[DIN_W-1 -: 8] = rx_data;

        timed_out = 1'b0;
        case (state)
            ADDR, WDATA: timed_out = !rx_valid && (timer == TO_LAST);
            RWAIT:       timed_out = !rd_ack && (timer == TO_LAST);
            default:     timed_out = 1'b0;
        endcase

        status_cmd = (state == IDLE) && rx_valid && (rx_data == CMD_STATUS);

        // All error sources collapse into one flag so a cycle never counts twice.
        err_event = timed_out;
        case (state)
            IDLE: begin
                if (rx_valid && !(rx_data inside {CMD_WRITE, CMD_READ, CMD_SWRST, CMD_RUN, CMD_STATUS}))
                    err_event = 1'b1;
            end
            WCOMMIT, RWAIT, RDATA, RESP: begin
                if (rx_valid)
                    err_event = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            is_read  <= 1'b0;
            byte_cnt <= '0;
            timer    <= '0;
            rd_buf   <= '0;
            addr     <= '0;
            wr_data  <= '0;
            wr_en    <= 1'b0;
            rd_req   <= 1'b0;
            swrst    <= 1'b0;
            run      <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            err_cnt  <= 8'h00;
        end else begin
            wr_en <= 1'b0;
            swrst <= 1'b0;
            run   <= 1'b0;

            if (status_cmd)
                err_cnt <= 8'h00;
            else if (err_event && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        byte_cnt <= '0;
                        timer    <= '0;
                        case (rx_data)
                            CMD_WRITE: begin
                                is_read <= 1'b0;
                                state   <= ADDR;
                            end
                            CMD_READ: begin
                                is_read <= 1'b1;
                                state   <= ADDR;
                            end
                            CMD_SWRST: begin
                                swrst    <= 1'b1;
                                tx_data  <= ACK;
                                tx_valid <= 1'b1;
                                state    <= RESP;
                            end
                            CMD_RUN: begin
                                run      <= 1'b1;
                                tx_data  <= ACK;
                                tx_valid <= 1'b1;
                                state    <= RESP;
                            end
                            CMD_STATUS: begin
                                tx_data  <= err_cnt;
                                tx_valid <= 1'b1;
                                state    <= RESP;
                            end
                            default: begin
                                tx_data  <= NAK;
                                tx_valid <= 1'b1;
                                state    <= RESP;
                            end
                        endcase
                    end
                end

                ADDR: begin
                    if (rx_valid) begin
                        addr  <= addr_next;
                        timer <= '0;
                        if (byte_cnt == ADDR_LAST) begin
                            byte_cnt <= '0;
                            if (is_read) begin
                                rd_req <= 1'b1;
                                state  <= RWAIT;
                            end else begin
                                state  <= WDATA;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (timed_out) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                WDATA: begin
                    if (rx_valid) begin
                        wr_data <= wdata_next;
                        timer   <= '0;
                        if (byte_cnt == WR_LAST) begin
                            byte_cnt <= '0;
                            wr_en    <= 1'b1;
                            state    <= WCOMMIT;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (timed_out) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                WCOMMIT: begin
                    tx_data  <= ACK;
                    tx_valid <= 1'b1;
                    state    <= RESP;
                end

                // First read byte is offered straight from rd_data; the rest drain from rd_buf.
                RWAIT: begin
                    if (rd_ack) begin
                        rd_req   <= 1'b0;
                        tx_data  <= rd_data[DOUT_W-1 -: 8];
                        rd_buf   <= rd_data << 8;
                        tx_valid <= 1'b1;
                        byte_cnt <= '0;
                        state    <= RDATA;
                    end else if (timed_out) begin
                        rd_req   <= 1'b0;
                        tx_data  <= NAK;
                        tx_valid <= 1'b1;
                        state    <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                RDATA: begin
                    if (tx_valid && tx_ready) begin
                        if (byte_cnt == RD_LAST) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            tx_data  <= rd_buf[DOUT_W-1 -: 8];
                            rd_buf   <= rd_buf << 8;
                        end
                    end
                end

                RESP: begin
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Frame-level bench for uart_cmd_ctrl: random command frames are predicted by a
// transaction model (expected TX bytes, writes, pulses, error count) and compared.
module tb_uart_cmd_ctrl;

    localparam int DIN_W       = 32;
    localparam int DOUT_W      = 32;
    localparam int ADDR_BYTES  = 2;
    localparam int TIMEOUT_CYC = 16;

    localparam int K_WR   = 0;
    localparam int K_RD   = 1;
    localparam int K_SW   = 2;
    localparam int K_RUN  = 3;
    localparam int K_ST   = 4;
    localparam int K_BAD  = 5;
    localparam int K_PART = 6;
    localparam int K_RTO  = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic [15:0] addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        rd_req;
    logic        rd_ack = 1'b0;
    logic [31:0] rd_data = '0;
    logic        swrst;
    logic        run;
    logic [7:0]  err_cnt;

    int errors = 0;
    int checks = 0;
    int m_err  = 0;

    int          rdy_mode  = 1;
    bit          ack_en    = 1'b0;
    int          ack_delay = 0;
    logic [31:0] ack_val   = '0;
    int          wait_cnt  = 0;

    logic [7:0]  tx_q[$];
    logic [47:0] wr_q[$];
    int swrst_n = 0;
    int run_n   = 0;
    int rdreq_n = 0;

    uart_cmd_ctrl #(
        .DIN_W      (DIN_W),
        .DOUT_W     (DOUT_W),
        .ADDR_BYTES (ADDR_BYTES),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data (tx_data),
        .addr    (addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .rd_req  (rd_req),
        .rd_ack  (rd_ack),
        .rd_data (rd_data),
        .swrst   (swrst),
        .run     (run),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    // TX sink: held low, always ready, or randomly ready
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'b1;
            default: tx_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Read responder: acks after ack_delay cycles of rd_req
    always @(posedge clk) begin
        #1;
        rd_ack = 1'b0;
        if (rd_req && ack_en) begin
            if (wait_cnt == ack_delay) begin
                rd_ack   = 1'b1;
                rd_data  = ack_val;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid && tx_ready) tx_q.push_back(tx_data);
            if (wr_en) wr_q.push_back({addr, wr_data});
            if (swrst) swrst_n++;
            if (run) run_n++;
            if (rd_req) rdreq_n++;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bumpErr();
        m_err = (m_err < 255) ? m_err + 1 : 255;
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int kind, input logic [15:0] a, input logic [31:0] d,
                                 input int n, input bit hold);
        logic [7:0] frame[$];
        logic [7:0] full[$];
        logic [7:0] exp_tx[$];
        bit exp_wr;
        int exp_sw, exp_run, exp_rq, settle;
        int base_tx, base_wr, base_sw, base_run, base_rq;
        exp_wr   = 1'b0;
        exp_sw   = 0;
        exp_run  = 0;
        exp_rq   = -1;
        settle   = 3;
        base_tx  = tx_q.size();
        base_wr  = wr_q.size();
        base_sw  = swrst_n;
        base_run = run_n;
        base_rq  = rdreq_n;

        full.push_back(8'h10);
        full.push_back(a[15:8]);
        full.push_back(a[7:0]);
        full.push_back(d[7:0]);
        full.push_back(d[15:8]);
        full.push_back(d[23:16]);
        full.push_back(d[31:24]);

        case (kind)
            K_WR: begin
                frame = full;
                exp_tx.push_back(8'hA5);
                exp_wr = 1'b1;
            end
            K_RD, K_RTO: begin
                frame.push_back(8'h20);
                frame.push_back(a[15:8]);
                frame.push_back(a[7:0]);
                if (kind == K_RD) begin
                    ack_en    = 1'b1;
                    ack_delay = n;
                    ack_val   = d;
                    exp_tx.push_back(d[31:24]);
                    exp_tx.push_back(d[23:16]);
                    exp_tx.push_back(d[15:8]);
                    exp_tx.push_back(d[7:0]);
                    exp_rq = n + 1;
                end else begin
                    ack_en = 1'b0;
                    exp_tx.push_back(8'h5A);
                    exp_rq = TIMEOUT_CYC;
                    bumpErr();
                end
            end
            K_SW: begin
                frame.push_back(8'h30);
                exp_tx.push_back(8'hA5);
                exp_sw = 1;
            end
            K_RUN: begin
                frame.push_back(8'h40);
                exp_tx.push_back(8'hA5);
                exp_run = 1;
            end
            K_ST: begin
                frame.push_back(8'h50);
                exp_tx.push_back(8'(m_err));
                m_err = 0;
            end
            K_BAD: begin
                frame.push_back(d[7:0]);
                exp_tx.push_back(8'h5A);
                bumpErr();
            end
            default: begin
                for (int i = 0; i <= n; i++) frame.push_back(full[i]);
                bumpErr();
                settle = TIMEOUT_CYC + 4;
            end
        endcase

        if (hold) rdy_mode = 0;
        foreach (frame[i]) begin
            sendByte(frame[i]);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        if (hold) begin
            sendByte(8'hC3);
            bumpErr();
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                checkOutput("held_tx_valid", 64'(tx_valid), 64'(1));
                checkOutput("held_tx_data", 64'(tx_data), 64'(exp_tx[0]));
            end
            rdy_mode = 1;
        end

        for (int c = 0; c < 400 && (tx_q.size() - base_tx) < exp_tx.size(); c++) @(negedge clk);
        repeat (settle) @(negedge clk);

        checkOutput($sformatf("tx_count_k%0d", kind), 64'(tx_q.size() - base_tx), 64'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && (base_tx + i) < tx_q.size(); i++)
            checkOutput($sformatf("tx_byte%0d_k%0d", i, kind), 64'(tx_q[base_tx + i]), 64'(exp_tx[i]));
        checkOutput($sformatf("wr_count_k%0d", kind), 64'(wr_q.size() - base_wr), 64'(exp_wr));
        if (exp_wr && wr_q.size() > base_wr)
            checkOutput("wr_addr_data", 64'(wr_q[base_wr]), 64'({a, d}));
        checkOutput($sformatf("swrst_pulses_k%0d", kind), 64'(swrst_n - base_sw), 64'(exp_sw));
        checkOutput($sformatf("run_pulses_k%0d", kind), 64'(run_n - base_run), 64'(exp_run));
        if (exp_rq >= 0)
            checkOutput($sformatf("rd_req_cycles_k%0d", kind), 64'(rdreq_n - base_rq), 64'(exp_rq));
        checkOutput($sformatf("err_cnt_k%0d", kind), 64'(err_cnt), 64'(m_err));
        ack_en = 1'b0;
    endtask

    initial begin
        int kind, n;
        bit hold;
        logic [15:0] a;
        logic [31:0] d;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx_valid", 64'(tx_valid), 64'(0));
        checkOutput("reset_wr_en", 64'(wr_en), 64'(0));
        checkOutput("reset_rd_req", 64'(rd_req), 64'(0));
        checkOutput("reset_pulses", 64'({swrst, run}), 64'(0));
        checkOutput("reset_err_cnt", 64'(err_cnt), 64'(0));
        checkOutput("reset_addr_data", 64'({addr, wr_data}), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        rdy_mode = 1;
        applyStimulus(K_WR, 16'h1234, 32'hDEADBEEF, 0, 1'b0);
        applyStimulus(K_RD, 16'h0007, 32'hCAFEF00D, 4, 1'b0);
        applyStimulus(K_SW, 16'h0, 32'h0, 0, 1'b1);
        applyStimulus(K_RUN, 16'h0, 32'h0, 0, 1'b0);
        applyStimulus(K_ST, 16'h0, 32'h0, 0, 1'b0);
        applyStimulus(K_PART, 16'h0001, 32'h000000AA, 3, 1'b0);
        applyStimulus(K_BAD, 16'h0, 32'h00000077, 0, 1'b0);
        applyStimulus(K_ST, 16'h0, 32'h0, 0, 1'b0);
        applyStimulus(K_RTO, 16'h0007, 32'h0, 0, 1'b0);

        // Reset while read data is being offered
        rdy_mode  = 0;
        ack_en    = 1'b1;
        ack_delay = 2;
        ack_val   = 32'hCAFEF00D;
        sendByte(8'h20);
        sendByte(8'h00);
        sendByte(8'h07);
        for (int c = 0; c < 50 && !tx_valid; c++) @(negedge clk);
        checkOutput("rdata_offered", 64'(tx_valid), 64'(1));
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_rdata_tx_valid", 64'(tx_valid), 64'(0));
        checkOutput("rst_rdata_rd_req", 64'(rd_req), 64'(0));
        checkOutput("rst_rdata_err_cnt", 64'(err_cnt), 64'(0));
        ack_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        m_err    = 0;
        rdy_mode = 1;
        applyStimulus(K_WR, 16'hA55A, 32'h01234567, 0, 1'b0);

        // Reset while a read request is outstanding
        sendByte(8'h20);
        sendByte(8'h00);
        sendByte(8'h07);
        repeat (3) @(negedge clk);
        checkOutput("rwait_rd_req", 64'(rd_req), 64'(1));
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_rwait_rd_req", 64'(rd_req), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        m_err = 0;

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 7);
            a    = 16'($urandom);
            d    = $urandom;
            n    = 0;
            if (kind == K_RD) n = $urandom_range(0, 8);
            if (kind == K_PART) n = $urandom_range(1, 5);
            if (kind == K_BAD)
                while (d[7:0] inside {8'h10, 8'h20, 8'h30, 8'h40, 8'h50}) d = $urandom;
            hold     = (kind >= K_SW) && (kind <= K_BAD) && ($urandom_range(0, 2) == 0);
            rdy_mode = $urandom_range(1, 2);
            applyStimulus(kind, a, d, n, hold);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
